fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_3000, first fetch address after reset.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: imem_req  output  1  instruction-memory request valid.
REQ-005 Port: imem_addr  output  32  instruction-memory byte address.
REQ-006 Port: imem_gnt  input  1  memory accepted the request this cycle.
REQ-007 Port: imem_rvalid  input  1  read data valid for the outstanding request.
REQ-008 Port: imem_rdata  input  32  instruction word.
REQ-009 Port: instr_valid  output  1  buffered instruction available to decode.
REQ-010 Port: instr  output  32  buffered instruction word.
REQ-011 Port: instr_pc  output  32  address of the buffered instruction; feeds next-PC unit PC input.
REQ-012 Port: instr_ready  input  1  decode consumes the buffered instruction this cycle.
REQ-013 Port: redirect  input  1  control transfer resolved; fetch resumes at redirect_pc.
REQ-014 Port: redirect_pc  input  32  target from the next-PC unit (branch/j/jal/jr/jalr).
REQ-015 Port: addr_err  output  1  misaligned redirect target (see Configuration).

Function
REQ-016 FSM states IDLE, REQ, WAIT, HOLD; internal fetch_pc (32 bit), kill flag (1 bit), one-entry instruction buffer.
REQ-017 IDLE: all outputs low; unconditionally -> REQ next cycle; redirect ignored.
REQ-018 REQ: imem_req=1, imem_addr=fetch_pc; imem_addr changes only on redirect; imem_gnt=1 -> WAIT.
REQ-019 At most one request outstanding; imem_gnt outside REQ and imem_rvalid outside WAIT are ignored.
REQ-020 WAIT, imem_rvalid=1, kill=0: instr<=imem_rdata, instr_pc<=fetch_pc, fetch_pc<=fetch_pc+4, -> HOLD.
REQ-021 WAIT, imem_rvalid=1, kill=1: data dropped, kill<=0, -> REQ.
REQ-022 HOLD: instr_valid=1, instr/instr_pc stable; instr_ready=1 -> REQ (instr_valid low next cycle).
REQ-023 fetch_pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 redirect in REQ without gnt: fetch_pc<=redirect_pc, stay REQ.
REQ-025 redirect in REQ with gnt same cycle: fetch_pc<=redirect_pc, kill<=1, -> WAIT.
REQ-026 redirect in WAIT without rvalid: fetch_pc<=redirect_pc, kill<=1, stay WAIT; with rvalid same cycle: data dropped, kill<=0, -> REQ.
REQ-027 redirect in HOLD: buffer discarded, fetch_pc<=redirect_pc, -> REQ; redirect has priority over instr_ready.
REQ-028 Minimum latency: redirect to imem_req at new address = 1 cycle (from REQ/HOLD).

Reset
REQ-029 reset_n=0 asynchronously forces state=IDLE, fetch_pc=RESET_PC, kill=0, imem_req=0, instr_valid=0, instr=0, instr_pc=0, addr_err=0.
REQ-030 Reset mid-request: outstanding transaction abandoned; later imem_rvalid ignored until a new grant.

Configuration
REQ-031 Macro FETCH_CTRL_ALIGN_CHK_EN defined: redirect with redirect_pc[1:0]!=0 is ignored (no state change) and addr_err pulses high for exactly 1 cycle.
REQ-032 Macro undefined: addr_err tied 0; redirect_pc[1:0] forced to 2'b00 when loaded.

Structure
REQ-033 Shared package fetch_pkg: FSM state encoding, RESET_PC default, PC increment constant 4.
REQ-034 Single module; no sub-module is natural at this size.

Verification
REQ-035 Reset release, gnt and rvalid 1 cycle after each request, instr_ready=1 -> imem_addr sequence 0x3000, 0x3004, 0x3008; instr_pc matches.
REQ-036 redirect=1, redirect_pc=0x3100 in WAIT, rvalid next cycle -> that word dropped, next imem_addr=0x3100, no instr_valid for dropped word.
REQ-037 redirect with imem_gnt and imem_rvalid in same cycle as redirect (REQ and WAIT cases) -> no stale instruction reaches decode.
REQ-038 HOLD with instr_ready=0 for 5 cycles -> instr/instr_pc stable, imem_req=0; ready=1 -> imem_req next cycle at instr_pc+4.
REQ-039 fetch at 0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000.
REQ-040 With FETCH_CTRL_ALIGN_CHK_EN, redirect_pc=0x3102 -> addr_err 1-cycle pulse, fetch continues sequentially; without macro -> imem_addr=0x3100.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding and PC constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StHold = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_INCR          = 32'd4;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, one-entry decode buffer.
// Optional macro FETCH_CTRL_ALIGN_CHK_EN rejects misaligned redirect targets and flags addr_err.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        addr_err
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_fetch_pc, w_fetch_pc_nxt;
  logic         r_kill, w_kill_nxt;
  logic [31:0]  r_instr, r_instr_pc;
  logic         w_load;
  logic         w_active;
  logic         w_redir;
  logic [31:0]  w_target;

  assign w_active = (r_state != StIdle);

`ifdef FETCH_CTRL_ALIGN_CHK_EN
  logic w_misaligned;
  logic r_addr_err;

  assign w_misaligned = (redirect_pc[1:0] != 2'b00);
  assign w_redir      = redirect && w_active && !w_misaligned;
  assign w_target     = redirect_pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= redirect && w_active && w_misaligned;
    end
  end

  assign addr_err = r_addr_err;
`else
  assign w_redir  = redirect && w_active;
  assign w_target = redirect_pc & 32'hFFFF_FFFC;
  assign addr_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_fetch_pc <= RESET_PC;
      r_kill     <= 1'b0;
      r_instr    <= 32'h0;
      r_instr_pc <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_kill     <= w_kill_nxt;
      if (w_load) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_fetch_pc;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_kill_nxt     = r_kill;
    w_load         = 1'b0;
    unique case (r_state)
      StIdle: w_state_nxt = StReq;
      StReq: begin
        if (w_redir) w_fetch_pc_nxt = w_target;
        // A granted request for the old address must be dropped when it returns.
        if (imem_gnt) begin
          w_state_nxt = StWait;
          w_kill_nxt  = w_redir;
        end
      end
      StWait: begin
        if (w_redir) w_fetch_pc_nxt = w_target;
        if (imem_rvalid) begin
          if (r_kill || w_redir) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = StReq;
          end else begin
            w_load         = 1'b1;
            w_fetch_pc_nxt = r_fetch_pc + PC_INCR;
            w_state_nxt    = StHold;
          end
        end else if (w_redir) begin
          w_kill_nxt = 1'b1;
        end
      end
      StHold: begin
        if (w_redir) begin
          w_fetch_pc_nxt = w_target;
          w_state_nxt    = StReq;
        end else if (instr_ready) begin
          w_state_nxt = StReq;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign imem_req    = (r_state == StReq);
  assign imem_addr   = imem_req ? r_fetch_pc : 32'h0;
  assign instr_valid = (r_state == StHold);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, corner sequences, random run.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
`ifdef FETCH_CTRL_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        addr_err;

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
  endtask

  task automatic do_reset();
    clear_in();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic add(input logic gnt, input logic rv, input logic [31:0] rdata,
                     input logic rdy, input logic redir, input logic [31:0] rpc,
                     input logic req, input logic [31:0] addr, input logic valid,
                     input logic [31:0] ins, input logic [31:0] ipc, input logic err);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.req = req; v.addr = addr; v.valid = valid; v.instr = ins; v.ipc = ipc; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic run_table();
    logic [31:0] a;
    a = ALIGN ? 32'h3400 : 32'h3500;
    //   gnt rv rdata          rdy rd rpc            req addr          vld instr          ipc     err
    add(0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,        0, 32'h0,         32'h0,    0);
    add(1, 1, 32'hBAD0_0001,  0, 0, 32'h0,         1, 32'h3000,     0, 32'h0,         32'h0,    0);
    add(0, 1, 32'hD000_0000,  0, 0, 32'h0,         0, 32'h0,        0, 32'h0,         32'h0,    0);
    add(0, 1, 32'hBAD0_0002,  1, 0, 32'h0,         0, 32'h0,        1, 32'hD000_0000, 32'h3000, 0);
    add(1, 0, 32'h0,          0, 0, 32'h0,         1, 32'h3004,     0, 32'h0,         32'h0,    0);
    add(0, 1, 32'hD000_0001,  0, 0, 32'h0,         0, 32'h0,        0, 32'h0,         32'h0,    0);
    add(0, 0, 32'h0,          1, 0, 32'h0,         0, 32'h0,        1, 32'hD000_0001, 32'h3004, 0);
    add(1, 0, 32'h0,          0, 0, 32'h0,         1, 32'h3008,     0, 32'h0,         32'h0,    0);
    add(0, 1, 32'hD000_0002,  0, 0, 32'h0,         0, 32'h0,        0, 32'h0,         32'h0,    0);
    add(0, 0, 32'h0,          1, 0, 32'h0,         0, 32'h0,        1, 32'hD000_0002, 32'h3008, 0);
    add(1, 0, 32'h0,          0, 0, 32'h0,         1, 32'h300C,     0, 32'h0,         32'h0,    0);
    add(0, 0, 32'h0,          0, 1, 32'h3100,      0, 32'h0,        0, 32'h0,         32'h0,    0);
    add(0, 1, 32'hBAD0_0003,  0, 0, 32'h0,         0, 32'h0,        0, 32'h0,         32'h0,    0);
    add(1, 0, 32'h0,          0, 1, 32'h3200,      1, 32'h3100,     0, 32'h0,         32'h0,    0);
    add(0, 1, 32'hBAD0_0004,  0, 0, 32'h0,         0, 32'h0,        0, 32'h0,         32'h0,    0);
    add(1, 0, 32'h0,          0, 0, 32'h0,         1, 32'h3200,     0, 32'h0,         32'h0,    0);
    add(0, 1, 32'hBAD0_0005,  0, 1, 32'h3300,      0, 32'h0,        0, 32'h0,         32'h0,    0);
    add(1, 0, 32'h0,          0, 0, 32'h0,         1, 32'h3300,     0, 32'h0,         32'h0,    0);
    add(0, 1, 32'hD000_0003,  0, 0, 32'h0,         0, 32'h0,        0, 32'h0,         32'h0,    0);
    add(1, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,        1, 32'hD000_0003, 32'h3300, 0);
    add(0, 0, 32'h0,          1, 1, 32'h3400,      0, 32'h0,        1, 32'hD000_0003, 32'h3300, 0);
    add(0, 0, 32'h0,          0, 1, 32'h3502,      1, 32'h3400,     0, 32'h0,         32'h0,    0);
    add(0, 0, 32'h0,          0, 0, 32'h0,         1, a,            0, 32'h0,         32'h0,    ALIGN);
    add(1, 0, 32'h0,          0, 0, 32'h0,         1, a,            0, 32'h0,         32'h0,    0);
    add(0, 1, 32'hD000_0004,  0, 0, 32'h0,         0, 32'h0,        0, 32'h0,         32'h0,    0);
    add(0, 0, 32'h0,          1, 0, 32'h0,         0, 32'h0,        1, 32'hD000_0004, a,        0);
    add(0, 0, 32'h0,          0, 0, 32'h0,         1, a + 32'd4,    0, 32'h0,         32'h0,    0);

    do_reset();
    foreach (vecs[i]) begin
      imem_gnt    = vecs[i].gnt;
      imem_rvalid = vecs[i].rv;
      imem_rdata  = vecs[i].rdata;
      instr_ready = vecs[i].rdy;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      chk($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
      chk($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].valid});
      chk($sformatf("vec%0d_addr_err", i), {31'b0, addr_err}, {31'b0, vecs[i].err});
      if (vecs[i].req) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
      if (vecs[i].valid) begin
        chk($sformatf("vec%0d_instr", i), instr, vecs[i].instr);
        chk($sformatf("vec%0d_instr_pc", i), instr_pc, vecs[i].ipc);
      end
      step();
    end
    clear_in();
  endtask

  task automatic run_corners();
    // Decode stall: buffer must hold, no new request until consumed.
    do_reset();
    step();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0; instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_instr", instr, 32'hDEAD_BEEF);
      chk("stall_pc", instr_pc, 32'h3000);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      step();
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("stall_release_req", {31'b0, imem_req}, 32'd1);
    chk("stall_release_addr", imem_addr, 32'h3004);
    chk("stall_release_valid", {31'b0, instr_valid}, 32'd0);

    // PC wrap at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0;
    chk("wrap_valid", {31'b0, instr_valid}, 32'd1);
    chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("wrap_req", {31'b0, imem_req}, 32'd1);
    chk("wrap_addr_zero", imem_addr, 32'h0);

    // Reset with a request outstanding; the late response must be ignored.
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_rst_req", {31'b0, imem_req}, 32'd0);
    chk("async_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("async_rst_instr", instr, 32'h0);
    chk("async_rst_pc", instr_pc, 32'h0);
    chk("async_rst_err", {31'b0, addr_err}, 32'd0);
    step();
    reset_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_00FF;
    step();
    chk("rst_stale_req", {31'b0, imem_req}, 32'd1);
    chk("rst_stale_addr", imem_addr, RST_PC);
    step();
    chk("rst_stale_still_req", {31'b0, imem_req}, 32'd1);
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h600D_0000;
    step();
    imem_rvalid = 1'b0;
    chk("rst_new_valid", {31'b0, instr_valid}, 32'd1);
    chk("rst_new_instr", instr, 32'h600D_0000);
    chk("rst_new_pc", instr_pc, RST_PC);
    clear_in();
  endtask

  // Model: decode must see words in program order from the last accepted redirect.
  task automatic run_random(input int n);
    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    logic [31:0] tgt;
    logic        exp_err;
    logic        pending;
    logic        mis;
    logic        acc;
    int          lat;
    int          stall;
    exp_pc = RST_PC; pend_addr = 32'h0; exp_err = 1'b0; pending = 1'b0; lat = 0; stall = 0;
    do_reset();
    for (int c = 0; c < n; c++) begin
      chk("rand_single_outstanding", {31'b0, imem_req && pending}, 32'd0);
      chk("rand_addr_err", {31'b0, addr_err}, {31'b0, exp_err});
      if (instr_valid) begin
        chk("rand_instr_pc", instr_pc, exp_pc);
        chk("rand_instr", instr, memf(exp_pc));
        stall = 0;
      end else begin
        stall++;
        if (stall > 200) begin
          n_chk++;
          n_err++;
          $display("FAIL rand_progress: got no instruction for %0d cycles, expected one", stall);
          break;
        end
      end

      imem_gnt    = 1'($urandom_range(0, 1));
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pending) begin
        if (lat == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memf(pend_addr);
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        imem_rvalid = 1'b1;
      end
      instr_ready = ($urandom_range(0, 2) != 0);
      redirect    = (c != 0) && ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));

      mis     = (redirect_pc[1:0] != 2'b00);
      acc     = redirect && !(ALIGN && mis);
      exp_err = redirect && ALIGN && mis;
      tgt     = redirect_pc & 32'hFFFF_FFFC;
      if (acc) exp_pc = tgt;
      else if (instr_valid && instr_ready) exp_pc = exp_pc + 32'd4;
      if (pending && imem_rvalid) begin
        pending = 1'b0;
      end else if (imem_req && imem_gnt) begin
        pending   = 1'b1;
        pend_addr = imem_addr;
        lat       = $urandom_range(0, 3);
      end
      step();
    end
    clear_in();
  endtask

  initial begin
    reset_n = 1'b0;
    clear_in();
    run_table();
    run_corners();
    run_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
